// File: rtl/imem_boot_loader_pkg.sv
// Purpose : shared types and frame constants for the instruction-memory boot loader.
// Latency : n/a (package only).
// Backpressure: n/a.
package imem_boot_loader_pkg;

  // Loader FSM states, in frame order.
  typedef enum logic [2:0] {
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam int LEN_BYTES      = 2;              // word-count field, little-endian
  localparam int LEN_W          = 8 * LEN_BYTES;  // length register / compare width
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);
  localparam int CSUM_W         = 8;              // XOR of payload bytes

endpackage

// File: rtl/imem_boot_loader_if.sv
// Purpose : byte-stream input and instruction-memory write port of the boot loader.
// Latency : n/a (signal bundle).
// Backpressure: in_ready qualifies in_valid; the write port has no backpressure.
// Ports   : in_valid/in_data/in_ready (host byte stream),
//           imem_we/imem_addr/imem_wdata (one-cycle word write strobe).
interface imem_boot_loader_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // Host / memory side: drives the byte stream, observes the write port.
  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Purpose : packs accepted bytes little-endian into 32-bit words.
// Latency : word_vld_o pulses one cycle after the 4th byte of a word is accepted.
// Backpressure: none; a byte is taken whenever byte_vld_i is high.
// Ports   : clk/reset, clear_i (drop partial word), byte_vld_i/byte_dat_i (input bytes),
//           last_lane_o (next byte completes a word), word_vld_o/word_dat_o (output word).
module imem_boot_loader_byte_word_packer
  import imem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_dat_i,
  output logic        last_lane_o,
  output logic        word_vld_o,
  output logic [31:0] word_dat_o
);

  localparam int ASM_W = 8 * (BYTES_PER_WORD - 1);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [ASM_W-1:0]  asm_q, asm_d;       // lower bytes of the word in progress
  logic              word_vld_q, word_vld_d;
  logic [31:0]       word_dat_q, word_dat_d;

  assign last_lane_o = (lane_q == LANE_W'(BYTES_PER_WORD - 1));

  always_comb begin
    lane_d     = lane_q;
    asm_d      = asm_q;
    word_vld_d = 1'b0;
    word_dat_d = word_dat_q;  // hold last word so the write data stays stable
    if (clear_i) begin
      lane_d = '0;
      asm_d  = '0;
    end else if (byte_vld_i) begin
      if (last_lane_o) begin
        // Top byte comes straight from the input; no need to store it first.
        word_vld_d = 1'b1;
        word_dat_d = {byte_dat_i, asm_q};
        lane_d     = '0;
      end else begin
        asm_d[{lane_q, 3'b000} +: 8] = byte_dat_i;
        lane_d = lane_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q     <= '0;
      asm_q      <= '0;
      word_vld_q <= 1'b0;
      word_dat_q <= '0;
    end else begin
      lane_q     <= lane_d;
      asm_q      <= asm_d;
      word_vld_q <= word_vld_d;
      word_dat_q <= word_dat_d;
    end
  end

  assign word_vld_o = word_vld_q;
  assign word_dat_o = word_dat_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Purpose : loads a framed program image (LEN, payload, XOR checksum) into instruction memory,
//           holding the core in reset until a verified image is written.
// Latency : word write one cycle after its 4th byte; load_done/load_error one cycle after checksum.
// Backpressure: in_ready high in LEN0/LEN1/DATA/CHECK (low during reset, DONE and ERROR).
// Ports   : clk, reset (sync, active-high); bus (slave: byte stream + imem write port);
//           reload (restart from DONE/ERROR); cpu_reset, load_done, load_error (status).
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int MEM_DEPTH = 64,
  parameter int ADDR_W    = 6
) (
  input  logic                clk,
  input  logic                reset,
  imem_boot_loader_if.slave   bus,
  input  logic                reload,
  output logic                cpu_reset,
  output logic                load_done,
  output logic                load_error
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CSUM_W-1:0]  csum_q, csum_d;
  logic [ADDR_W:0]    wcnt_q, wcnt_d;    // one extra bit so MEM_DEPTH is representable

  logic               accept;
  logic               rdy_state;
  logic [LEN_W-1:0]   full_len;
  logic               last_word;
  logic               pack_vld;
  logic               pack_clr;
  logic               last_lane;
  logic               word_vld;
  logic [31:0]        word_dat;

  assign rdy_state    = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                        (state_q == ST_DATA) || (state_q == ST_CHECK);
  // Gate with reset so nothing is taken while reset is held.
  assign bus.in_ready = rdy_state && !reset;
  assign accept       = bus.in_valid && bus.in_ready;

  assign full_len  = {bus.in_data, len_q[7:0]};
  // While the 4th byte of word k is arriving, the write of word k-1 has already
  // bumped the counter, so wcnt_q == k here.
  assign last_word = ((LEN_W'(wcnt_q) + LEN_W'(1)) == len_q);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    csum_d   = csum_q;
    wcnt_d   = wcnt_q;
    pack_vld = 1'b0;
    pack_clr = 1'b0;

    if (word_vld) wcnt_d = wcnt_q + 1'b1;

    case (state_q)
      ST_LEN0: begin
        if (accept) begin
          len_d[7:0] = bus.in_data;
          state_d    = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (accept) begin
          len_d = full_len;
          if (full_len == '0)                      state_d = ST_CHECK;
          else if (full_len > LEN_W'(MEM_DEPTH))   state_d = ST_ERROR;
          else                                     state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          pack_vld = 1'b1;
          csum_d   = csum_q ^ bus.in_data;
          if (last_lane && last_word) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (accept) state_d = (bus.in_data == csum_q) ? ST_DONE : ST_ERROR;
      end
      ST_DONE, ST_ERROR: begin
        if (reload) begin
          state_d  = ST_LEN0;
          len_d    = '0;
          csum_d   = '0;
          wcnt_d   = '0;
          pack_clr = 1'b1;
        end
      end
      default: state_d = ST_LEN0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LEN0;
      len_q   <= '0;
      csum_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      csum_q  <= csum_d;
      wcnt_q  <= wcnt_d;
    end
  end

  imem_boot_loader_byte_word_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (pack_clr),
    .byte_vld_i  (pack_vld),
    .byte_dat_i  (bus.in_data),
    .last_lane_o (last_lane),
    .word_vld_o  (word_vld),
    .word_dat_o  (word_dat)
  );

  assign bus.imem_we    = word_vld;
  assign bus.imem_addr  = wcnt_q[ADDR_W-1:0];
  assign bus.imem_wdata = word_dat;

  // Status decodes straight from the state register, so they change on state entry.
  assign cpu_reset  = (state_q != ST_DONE);
  assign load_done  = (state_q == ST_DONE);
  assign load_error = (state_q == ST_ERROR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Purpose : self-checking bench for imem_boot_loader against a frame-level reference model.
// Latency : n/a.
// Backpressure: n/a.
module tb_imem_boot_loader;

  localparam int MEM_DEPTH = 64;
  localparam int ADDR_W    = 6;

  logic clk = 1'b0;
  logic reset;
  logic reload;
  logic cpu_reset;
  logic load_done;
  logic load_error;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .reload     (reload),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Image payload for the current frame, one 32-bit word per entry.
  logic [31:0]       pay [0:MEM_DEPTH-1];
  // Writes observed on the memory port since the last clear.
  logic [ADDR_W-1:0] wr_addr_q [$];
  logic [31:0]       wr_data_q [$];

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr_q.push_back(bus.imem_addr);
      wr_data_q.push_back(bus.imem_wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference checksum: XOR of every payload byte of the first n words.
  function automatic logic [7:0] model_csum(input int n);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) x ^= pay[i][8*k +: 8];
    return x;
  endfunction

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  // Offer one byte; returns just after the posedge on which it was accepted.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int  budget = 0;
    bit  taken  = 1'b0;
    if (gaps)
      for (int g = 0; g < 6 && $urandom_range(0, 1) == 1; g++) idle();
    while (!taken) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        taken = 1'b1;
      end else begin
        budget++;
        if (budget >= 50) begin
          chk("handshake_timeout", 32'd0, 32'd1);
          bus.in_valid = 1'b0;
          taken = 1'b1;
        end
      end
    end
  endtask

  task automatic send_frame(input logic [15:0] len, input int nwords,
                            input logic [7:0] csum, input bit gaps);
    wr_addr_q.delete();
    wr_data_q.delete();
    send_byte(len[7:0], gaps);
    send_byte(len[15:8], gaps);
    for (int i = 0; i < nwords; i++)
      for (int k = 0; k < 4; k++) send_byte(pay[i][8*k +: 8], gaps);
    send_byte(csum, gaps);
    idle();  // lands on the cycle after the checksum handshake
  endtask

  task automatic check_result(input string tag, input bit exp_ok, input int exp_words);
    int n;
    chk({tag, "_load_done"},  32'(load_done),    32'(exp_ok));
    chk({tag, "_load_error"}, 32'(load_error),   32'(!exp_ok));
    chk({tag, "_cpu_reset"},  32'(cpu_reset),    32'(!exp_ok));
    chk({tag, "_in_ready"},   32'(bus.in_ready), 32'd0);
    chk({tag, "_nwrites"},    32'(wr_addr_q.size()), 32'(exp_words));
    n = (wr_addr_q.size() < exp_words) ? wr_addr_q.size() : exp_words;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[i]), 32'(i));
      chk($sformatf("%s_data%0d", tag, i), wr_data_q[i], pay[i]);
    end
  endtask

  task automatic do_reload(input string tag);
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk({tag, "_rl_cpu_reset"},  32'(cpu_reset),    32'd1);
    chk({tag, "_rl_load_done"},  32'(load_done),    32'd0);
    chk({tag, "_rl_load_error"}, 32'(load_error),   32'd0);
    chk({tag, "_rl_in_ready"},   32'(bus.in_ready), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"},   32'(bus.in_ready),   32'd0);
    chk({tag, "_imem_we"},    32'(bus.imem_we),    32'd0);
    chk({tag, "_imem_addr"},  32'(bus.imem_addr),  32'd0);
    chk({tag, "_imem_wdata"}, bus.imem_wdata,      32'd0);
    chk({tag, "_cpu_reset"},  32'(cpu_reset),      32'd1);
    chk({tag, "_load_done"},  32'(load_done),      32'd0);
    chk({tag, "_load_error"}, 32'(load_error),     32'd0);
  endtask

  task automatic set_small_image();
    pay[0] = 32'h0000_0513;
    pay[1] = 32'h0010_0593;
  endtask

  initial begin
    int         n;
    bit         bad;
    logic [7:0] cs;

    reset        = 1'b1;
    reload       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;

    // Two-word image, good checksum.
    set_small_image();
    send_frame(16'd2, 2, model_csum(2), 1'b0);
    check_result("good2", 1'b1, 2);

    // Same image, wrong checksum: writes still happen, then recover via reload.
    do_reload("r1");
    send_frame(16'd2, 2, 8'h00, 1'b0);
    check_result("badcs", 1'b0, 2);
    do_reload("r2");
    send_frame(16'd2, 2, model_csum(2), 1'b0);
    check_result("regood", 1'b1, 2);

    // Oversized length: error right after LEN_HI, nothing written.
    do_reload("r3");
    wr_addr_q.delete();
    wr_data_q.delete();
    send_byte(8'h41, 1'b0);
    send_byte(8'h00, 1'b0);
    idle();
    chk("len65_load_error", 32'(load_error),   32'd1);
    chk("len65_in_ready",   32'(bus.in_ready), 32'd0);
    chk("len65_cpu_reset",  32'(cpu_reset),    32'd1);
    repeat (8) idle();
    chk("len65_nwrites", 32'(wr_addr_q.size()), 32'd0);

    // Full-depth image.
    do_reload("r4");
    for (int i = 0; i < MEM_DEPTH; i++) pay[i] = $urandom;
    send_frame(16'd64, 64, model_csum(64), 1'b0);
    check_result("len64", 1'b1, 64);

    // Empty image.
    do_reload("r5");
    send_frame(16'd0, 0, 8'h00, 1'b0);
    check_result("len0_ok", 1'b1, 0);
    do_reload("r6");
    send_frame(16'd0, 0, 8'h01, 1'b0);
    check_result("len0_bad", 1'b0, 0);

    // Idle gaps between bytes.
    do_reload("r7");
    set_small_image();
    send_frame(16'd2, 2, model_csum(2), 1'b1);
    check_result("gaps", 1'b1, 2);

    // Random images, occasionally with a corrupted checksum.
    for (int t = 0; t < 4; t++) begin
      do_reload("rr");
      n   = $urandom_range(1, 12);
      bad = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < n; i++) pay[i] = $urandom;
      cs = model_csum(n) ^ (bad ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      send_frame(16'(n), n, cs, 1'b1);
      check_result($sformatf("rand%0d", t), !bad, n);
    end

    // Reset in the middle of the payload, then a clean reload from address 0.
    do_reload("r8");
    set_small_image();
    wr_addr_q.delete();
    wr_data_q.delete();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int j = 0; j < 6; j++) send_byte(pay[j/4][8*(j%4) +: 8], 1'b0);
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    chk("midrst_nwrites", 32'(wr_addr_q.size()), 32'd1);
    reset = 1'b0;
    pay[0] = 32'hDEAD_BEEF;
    pay[1] = 32'h0123_4567;
    send_frame(16'd2, 2, model_csum(2), 1'b0);
    check_result("postrst", 1'b1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
